// File: rtl/mem_width_bridge.sv
// ---------------------------------------------------------------------------
// mem_width_bridge
//
// Sits between the cache's wide memory-side port and a narrow external
// memory bus. Each wide access is split into Beats = MemBusWidth/ExtBusWidth
// narrow beats (little-endian: beat 0 carries the low slice). Reads are
// reassembled and returned with a one-cycle mem_r_data_valid pulse; a write
// is complete when mem_ready returns. One wide access in flight at a time.
//
// Ports
//   clk, rst              clock; asynchronous active-low reset
//   mem_addr/mem_w_data   cache request byte address / write data
//   mem_re/mem_we         cache read / write request (write wins if both)
//   mem_ready             idle; a request present this cycle is accepted
//   mem_r_data(_valid)    assembled read data and its one-cycle valid pulse
//   ext_addr/ext_w_data   current beat byte address / write data
//   ext_re/ext_we         beat read / write request
//   ext_ready             external side accepts the current beat this cycle
//   ext_r_data(_valid)    beat read data, returned in issue order
// ---------------------------------------------------------------------------
module mem_width_bridge #(
    parameter int unsigned AddrBusWidth = 32,
    parameter int unsigned MemBusWidth  = 64,
    parameter int unsigned ExtBusWidth  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AddrBusWidth-1:0] mem_addr,
    input  logic [MemBusWidth-1:0]  mem_w_data,
    input  logic                    mem_re,
    input  logic                    mem_we,
    output logic [MemBusWidth-1:0]  mem_r_data,
    output logic                    mem_ready,
    output logic                    mem_r_data_valid,
    output logic [AddrBusWidth-1:0] ext_addr,
    output logic [ExtBusWidth-1:0]  ext_w_data,
    output logic                    ext_re,
    output logic                    ext_we,
    input  logic                    ext_ready,
    input  logic [ExtBusWidth-1:0]  ext_r_data,
    input  logic                    ext_r_data_valid
);
    localparam int unsigned Beats   = MemBusWidth / ExtBusWidth;
    localparam int unsigned IdxW    = $clog2(Beats);
    localparam int unsigned CntW    = IdxW + 1;
    localparam int unsigned ExtOffW = $clog2(ExtBusWidth / 8);

    localparam logic [AddrBusWidth-1:0] BaseMask = ~AddrBusWidth'(MemBusWidth / 8 - 1);
    localparam logic [IdxW-1:0]         LastIdx  = IdxW'(Beats - 1);
    localparam logic [CntW-1:0]         BeatsCnt = CntW'(Beats);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [AddrBusWidth-1:0] base_q;
    logic [MemBusWidth-1:0]  wbuf_q;
    logic [MemBusWidth-1:0]  rbuf_q;
    logic [MemBusWidth-1:0]  rbuf_d;
    // issue_cnt is one bit wider than a beat index: in RD it must be able to
    // reach Beats while earlier beats are still returning data.
    logic [CntW-1:0]         issue_cnt_q;
    logic [IdxW-1:0]         issue_idx;
    logic [IdxW-1:0]         rcv_cnt_q;
    logic [AddrBusWidth-1:0] beat_addr;
    logic                    rd_last;

    always_comb begin
        issue_idx = issue_cnt_q[IdxW-1:0];
        // base is wide-word aligned, so the add never carries into the
        // wide-word part of the address.
        beat_addr = base_q + (AddrBusWidth'(issue_idx) << ExtOffW);
        rd_last   = (state_q == RD) && ext_r_data_valid && (rcv_cnt_q == LastIdx);
        rbuf_d    = rbuf_q;
        rbuf_d[rcv_cnt_q * ExtBusWidth +: ExtBusWidth] = ext_r_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_ready = 1'b0;
        ext_re    = 1'b0;
        ext_we    = 1'b0;
        case (state_q)
            IDLE: begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    state_d = WR;
                end else if (mem_re) begin
                    state_d = RD;
                end
            end
            RD: begin
                ext_re = (issue_cnt_q < BeatsCnt);
                if (rd_last) begin
                    state_d = IDLE;
                end
            end
            WR: begin
                ext_we = 1'b1;
                if (ext_ready && (issue_idx == LastIdx)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address and data are pure functions of registered state, so they
    // stay put for as long as a beat waits on ext_ready.
    always_comb begin
        ext_addr   = (ext_re || ext_we) ? beat_addr : '0;
        ext_w_data = ext_we ? wbuf_q[issue_idx * ExtBusWidth +: ExtBusWidth] : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q           <= '0;
            wbuf_q           <= '0;
            rbuf_q           <= '0;
            issue_cnt_q      <= '0;
            rcv_cnt_q        <= '0;
            mem_r_data       <= '0;
            mem_r_data_valid <= 1'b0;
        end else begin
            mem_r_data_valid <= rd_last;
            case (state_q)
                IDLE: begin
                    if (mem_re || mem_we) begin
                        base_q      <= mem_addr & BaseMask;
                        wbuf_q      <= mem_w_data;
                        issue_cnt_q <= '0;
                        rcv_cnt_q   <= '0;
                    end
                end
                RD: begin
                    if (ext_re && ext_ready) begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                    if (ext_r_data_valid) begin
                        rbuf_q    <= rbuf_d;
                        rcv_cnt_q <= rcv_cnt_q + 1'b1;
                    end
                    if (rd_last) begin
                        mem_r_data <= rbuf_d;
                    end
                end
                WR: begin
                    if (ext_ready) begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_width_bridge.sv
// ---------------------------------------------------------------------------
// tb_mem_width_bridge
//
// Directed bench for mem_width_bridge (64-bit cache side, 32-bit external
// side). A table of wide transactions with hand-computed beat addresses,
// beat data, read results and completion cycles is replayed against a small
// external-memory responder with programmable ready stalls and read latency.
// Hand-written sequences cover back-to-back reads and reset mid-access.
// Cycle 0 of a transaction is the cycle the request is presented.
// ---------------------------------------------------------------------------
module tb_mem_width_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [63:0] mem_w_data = '0;
    logic        mem_re = 1'b0;
    logic        mem_we = 1'b0;
    logic [63:0] mem_r_data;
    logic        mem_ready;
    logic        mem_r_data_valid;
    logic [31:0] ext_addr;
    logic [31:0] ext_w_data;
    logic        ext_re;
    logic        ext_we;
    logic        ext_ready = 1'b0;
    logic [31:0] ext_r_data = '0;
    logic        ext_r_data_valid = 1'b0;

    mem_width_bridge #(
        .AddrBusWidth(32),
        .MemBusWidth (64),
        .ExtBusWidth (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_addr        (mem_addr),
        .mem_w_data      (mem_w_data),
        .mem_re          (mem_re),
        .mem_we          (mem_we),
        .mem_r_data      (mem_r_data),
        .mem_ready       (mem_ready),
        .mem_r_data_valid(mem_r_data_valid),
        .ext_addr        (ext_addr),
        .ext_w_data      (ext_w_data),
        .ext_re          (ext_re),
        .ext_we          (ext_we),
        .ext_ready       (ext_ready),
        .ext_r_data      (ext_r_data),
        .ext_r_data_valid(ext_r_data_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- external memory responder ----------------
    int          r_stall;
    int          r_delay;
    int          wait_cnt;
    int          due_q[$];
    logic [31:0] dat_q[$];
    logic [31:0] rd_src[$];
    logic [31:0] seen_addr[$];
    logic [31:0] seen_wd[$];
    int          pulse_cyc[$];
    logic [63:0] pulse_data[$];
    logic        prev_req;
    logic [31:0] prev_addr;
    logic [31:0] prev_wd;
    int          stable_bad;
    int          both_bad;

    task automatic resp_clear(input int stall, input int delay);
        r_stall    = stall;
        r_delay    = delay;
        wait_cnt   = 0;
        prev_req   = 1'b0;
        stable_bad = 0;
        both_bad   = 0;
        due_q.delete();
        dat_q.delete();
        rd_src.delete();
        seen_addr.delete();
        seen_wd.delete();
        pulse_cyc.delete();
        pulse_data.delete();
    endtask

    // Inputs for this cycle, applied just after the rising edge.
    task automatic ext_drive(input int cyc);
        ext_ready = (wait_cnt >= r_stall);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            ext_r_data_valid = 1'b1;
            ext_r_data       = dat_q.pop_front();
            void'(due_q.pop_front());
        end else begin
            ext_r_data_valid = 1'b0;
            ext_r_data       = '0;
        end
    endtask

    // Observe settled outputs mid-cycle.
    task automatic ext_observe(input int cyc);
        if (ext_re && ext_we) both_bad++;
        if (prev_req && (ext_re || ext_we) && (ext_addr !== prev_addr || ext_w_data !== prev_wd))
            stable_bad++;
        prev_req = 1'b0;
        if (ext_re || ext_we) begin
            if (ext_ready) begin
                seen_addr.push_back(ext_addr);
                seen_wd.push_back(ext_w_data);
                wait_cnt = 0;
                if (ext_re) begin
                    due_q.push_back(cyc + r_delay);
                    dat_q.push_back(rd_src.size() > 0 ? rd_src.pop_front() : 32'hBAD0BAD0);
                end
            end else begin
                wait_cnt++;
                prev_req  = 1'b1;
                prev_addr = ext_addr;
                prev_wd   = ext_w_data;
            end
        end
        if (mem_r_data_valid) begin
            pulse_cyc.push_back(cyc);
            pulse_data.push_back(mem_r_data);
        end
    endtask

    // ---------------- transaction table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          stall;
        int          delay;
        logic [31:0] ea0;
        logic [31:0] ea1;
        logic [31:0] ew0;
        logic [31:0] ew1;
        logic [63:0] erdata;
        int          epulses;
        int          edone;
    } vec_t;

    vec_t        vecs[6];
    vec_t        post_rst;
    logic [63:0] last_rd = '0;

    task automatic run_vec(input vec_t v, input string tag);
        int done_cyc;
        bit accepted;
        resp_clear(v.stall, v.delay);
        rd_src.push_back(v.rd0);
        rd_src.push_back(v.rd1);
        chk({tag, "_held"}, mem_r_data, last_rd);
        done_cyc = -1;
        accepted = 1'b0;
        for (int cyc = 0; cyc < 60 && !(done_cyc >= 0 && cyc > done_cyc + 3); cyc++) begin
            mem_re     = !accepted && v.rd;
            mem_we     = !accepted && v.wr;
            mem_addr   = v.addr;
            mem_w_data = v.wdata;
            ext_drive(cyc);
            #1;
            ext_observe(cyc);
            if (mem_ready) begin
                if (!accepted) accepted = 1'b1;
                else if (done_cyc < 0) done_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        mem_re = 1'b0;
        mem_we = 1'b0;
        chk({tag, "_done_cycle"}, done_cyc, v.edone);
        chk({tag, "_beats"}, seen_addr.size(), 2);
        if (seen_addr.size() >= 2) begin
            chk({tag, "_addr0"}, seen_addr[0], v.ea0);
            chk({tag, "_addr1"}, seen_addr[1], v.ea1);
            if (v.wr) begin
                chk({tag, "_wdata0"}, seen_wd[0], v.ew0);
                chk({tag, "_wdata1"}, seen_wd[1], v.ew1);
            end
        end
        chk({tag, "_pulses"}, pulse_cyc.size(), v.epulses);
        if (v.epulses == 1 && pulse_cyc.size() >= 1) begin
            chk({tag, "_pulse_cycle"}, pulse_cyc[0], v.edone);
            chk({tag, "_rdata"}, pulse_data[0], v.erdata);
            last_rd = v.erdata;
        end
        chk({tag, "_stable"}, stable_bad, 0);
        chk({tag, "_re_we_excl"}, both_bad, 0);
    endtask

    int acc_cyc[$];

    initial begin
        //              rd    wr    addr          wdata                  rd0           rd1           st dl ea0           ea1           ew0           ew1           erdata                 p  done
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0104, 64'h0,                32'h1111_1111, 32'h2222_2222, 0, 1, 32'h0000_0100, 32'h0000_0104, 32'h0,        32'h0,        64'h2222_2222_1111_1111, 1, 4};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0208, 64'hAAAA_BBBB_CCCC_DDDD, 32'h0,      32'h0,         0, 1, 32'h0000_0208, 32'h0000_020C, 32'hCCCC_DDDD, 32'hAAAA_BBBB, 64'h0,                 0, 3};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_03F0, 64'h0,                32'hDEAD_BEEF, 32'h0BAD_F00D, 3, 5, 32'h0000_03F0, 32'h0000_03F4, 32'h0,        32'h0,        64'h0BAD_F00D_DEAD_BEEF, 1, 14};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_040C, 64'h0123_4567_89AB_CDEF, 32'h5555_5555, 32'h6666_6666, 0, 1, 32'h0000_0408, 32'h0000_040C, 32'h89AB_CDEF, 32'h0123_4567, 64'h0,          0, 3};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_07FF, 64'hFEDC_BA98_7654_3210, 32'h0,      32'h0,         2, 1, 32'h0000_07F8, 32'h0000_07FC, 32'h7654_3210, 32'hFEDC_BA98, 64'h0,          0, 7};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 64'h0,                32'hCAFE_F00D, 32'h55AA_55AA, 0, 2, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0,        32'h0,        64'h55AA_55AA_CAFE_F00D, 1, 5};
        post_rst = '{1'b1, 1'b0, 32'h0000_050C, 64'h0,               32'h1357_9BDF, 32'h2468_ACE0, 1, 1, 32'h0000_0508, 32'h0000_050C, 32'h0,        32'h0,        64'h2468_ACE0_1357_9BDF, 1, 6};

        // Reset values, checked while reset is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_r_valid", mem_r_data_valid, 0);
        chk("rst_r_data", mem_r_data, 0);
        chk("rst_ext_re", ext_re, 0);
        chk("rst_ext_we", ext_we, 0);
        chk("rst_ext_addr", ext_addr, 0);
        chk("rst_ext_w_data", ext_w_data, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Back-to-back reads with mem_re held high.
        resp_clear(0, 1);
        rd_src.push_back(32'hA1A1_A1A1);
        rd_src.push_back(32'hB2B2_B2B2);
        rd_src.push_back(32'hC3C3_C3C3);
        rd_src.push_back(32'hD4D4_D4D4);
        acc_cyc.delete();
        for (int cyc = 0; cyc < 30; cyc++) begin
            mem_re   = (acc_cyc.size() < 2);
            mem_addr = (acc_cyc.size() == 0) ? 32'h0000_0600 : 32'h0000_060C;
            ext_drive(cyc);
            #1;
            ext_observe(cyc);
            if (mem_ready && mem_re) acc_cyc.push_back(cyc);
            @(posedge clk);
            #1;
        end
        mem_re = 1'b0;
        chk("b2b_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() >= 2) begin
            chk("b2b_accept0", acc_cyc[0], 0);
            chk("b2b_accept1", acc_cyc[1], 4);
        end
        chk("b2b_pulses", pulse_cyc.size(), 2);
        if (pulse_cyc.size() >= 2) begin
            chk("b2b_pulse0_cycle", pulse_cyc[0], 4);
            chk("b2b_pulse1_cycle", pulse_cyc[1], 8);
            chk("b2b_rdata0", pulse_data[0], 64'hB2B2_B2B2_A1A1_A1A1);
            chk("b2b_rdata1", pulse_data[1], 64'hD4D4_D4D4_C3C3_C3C3);
        end
        chk("b2b_beats", seen_addr.size(), 4);
        if (seen_addr.size() >= 4) begin
            chk("b2b_addr2", seen_addr[2], 32'h0000_0608);
            chk("b2b_addr3", seen_addr[3], 32'h0000_060C);
        end

        // Reset after beat 0 of a read; its data arrives once back in IDLE.
        resp_clear(0, 3);
        rd_src.push_back(32'h9999_9999);
        rd_src.push_back(32'h8888_8888);
        for (int cyc = 0; cyc < 10; cyc++) begin
            mem_re   = (cyc == 0);
            mem_addr = 32'h0000_0500;
            rst      = !(cyc == 2 || cyc == 3);
            ext_drive(cyc);
            #1;
            ext_observe(cyc);
            @(posedge clk);
            #1;
        end
        chk("mrst_beats", seen_addr.size(), 1);
        chk("mrst_pulses", pulse_cyc.size(), 0);
        chk("mrst_r_data", mem_r_data, 0);
        chk("mrst_mem_ready", mem_ready, 1);
        chk("mrst_ext_re", ext_re, 0);
        last_rd = '0;
        run_vec(post_rst, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
